// File: rtl/uart_timing_pkg.sv
// Shared constants, frame-length helper and FSM state type for the UART frame timer.
package uart_timing_pkg;

  localparam int unsigned MIN_DIVISOR   = 2;
  localparam int unsigned MIN_DATA_BITS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slots in a frame: start + data + optional parity + one or two stops.
  function automatic logic [4:0] frame_len(input logic [3:0] d,
                                           input logic       p,
                                           input logic       two_stop);
    return 5'd1 + {1'b0, d} + {4'b0000, p} + (two_stop ? 5'd2 : 5'd1);
  endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-period generator: divisor counter with slot start/mid/last pulses.
// Optional macro UART_FRAC_BAUD_EN adds a fractional accumulator that
// stretches a slot by one clock on each accumulator carry.
module uart_bit_tick
  import uart_timing_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic                  tick_start,
  output logic                  tick_mid,
  output logic                  tick_last
);

  logic [DIV_WIDTH-1:0] per_q, per_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] slot_end;
  logic                 ext_w;

`ifdef UART_FRAC_BAUD_EN
  logic [FRAC_WIDTH-1:0] frac_q, frac_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  ext_q, ext_d;
  logic [FRAC_WIDTH:0]   sum;

  // Accumulate the fraction at every slot start; the carry stretches that slot.
  always_comb begin
    frac_d = frac_q;
    acc_d  = acc_q;
    ext_d  = ext_q;
    sum    = {1'b0, acc_q} + {1'b0, frac_q};
    if (load) begin
      frac_d = frac;
      acc_d  = '0;
      ext_d  = 1'b0;
    end else if (tick_start) begin
      acc_d = sum[FRAC_WIDTH-1:0];
      ext_d = sum[FRAC_WIDTH];
    end
  end

  // Fractional state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      frac_q <= '0;
      acc_q  <= '0;
      ext_q  <= 1'b0;
    end else begin
      frac_q <= frac_d;
      acc_q  <= acc_d;
      ext_q  <= ext_d;
    end
  end

  // ext_q is refreshed on the slot-start edge; it is only consulted from
  // count 1 onwards, which the minimum divisor of 2 guarantees.
  assign ext_w = ext_q;
`else
  logic unused_frac;
  assign unused_frac = ^frac;
  assign ext_w       = 1'b0;
`endif

  // Pulse decode and divisor counter next-state.
  always_comb begin
    per_d      = per_q;
    cnt_d      = cnt_q;
    slot_end   = per_q - DIV_WIDTH'(1) + DIV_WIDTH'(ext_w);
    tick_start = enable && (cnt_q == '0);
    tick_mid   = enable && (cnt_q == (per_q >> 1));
    tick_last  = enable && (cnt_q == slot_end);
    if (load) begin
      per_d = (divisor < DIV_WIDTH'(MIN_DIVISOR)) ? DIV_WIDTH'(MIN_DIVISOR) : divisor;
    end
    if (clear || tick_last) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Divisor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_q <= '0;
      cnt_q <= '0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_timer.sv
// UART frame timer: start/busy/done handshake with abort, slot index and
// per-slot start/mid pulses. Fractional baud enabled by UART_FRAC_BAUD_EN.
module uart_frame_timer
  import uart_timing_pkg::*;
#(
  parameter int unsigned DIV_WIDTH     = 16,
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned FRAC_WIDTH    = 4,
  parameter int unsigned IDX_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIV_WIDTH-1:0]  cfg_divisor,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  input  logic [3:0]            cfg_data_bits,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_two_stop,
  output logic                  busy,
  output logic                  bit_start,
  output logic                  bit_mid,
  output logic [IDX_WIDTH-1:0]  bit_index,
  output logic                  last_bit,
  output logic                  frame_done
);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] last_idx_q, last_idx_d;
  logic                 done_q, done_d;
  logic [3:0]           data_bits_c;
  logic                 load, clear;
  logic                 tick_start, tick_mid, tick_last;

  // Clamp the requested data-bit count into the legal range.
  always_comb begin
    data_bits_c = cfg_data_bits;
    if (cfg_data_bits < 4'(MIN_DATA_BITS)) begin
      data_bits_c = 4'(MIN_DATA_BITS);
    end else if (cfg_data_bits > 4'(MAX_DATA_BITS)) begin
      data_bits_c = 4'(MAX_DATA_BITS);
    end
  end

  // Frame FSM: accept, advance slot index on slot end, finish or abort.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = RUN;
          idx_d      = '0;
          last_idx_d = IDX_WIDTH'(frame_len(data_bits_c, cfg_parity_en, cfg_two_stop) - 5'd1);
          load       = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tick_last) begin
          if (idx_q == last_idx_q) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    clear = (state_d == IDLE) || load;
  end

  // FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      done_q     <= done_d;
    end
  end

  uart_bit_tick #(
    .DIV_WIDTH  (DIV_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_bit_tick (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .enable     (busy),
    .clear      (clear),
    .divisor    (cfg_divisor),
    .frac       (cfg_frac),
    .tick_start (tick_start),
    .tick_mid   (tick_mid),
    .tick_last  (tick_last)
  );

  assign busy       = (state_q == RUN);
  assign bit_start  = tick_start;
  assign bit_mid    = tick_mid;
  assign bit_index  = idx_q;
  assign last_bit   = busy && (idx_q == last_idx_q);
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_timer.sv
// Self-checking bench for uart_frame_timer: per-cycle reference model,
// table of frame formats, hand sequences and randomized traffic.
module tb_uart_frame_timer;

  localparam int DIV_WIDTH     = 16;
  localparam int MAX_DATA_BITS = 9;
  localparam int FRAC_WIDTH    = 4;
  localparam int IDX_WIDTH     = 4;

  logic                  clk = 1'b0;
  logic                  reset, start, abort;
  logic [DIV_WIDTH-1:0]  cfg_divisor;
  logic [FRAC_WIDTH-1:0] cfg_frac;
  logic [3:0]            cfg_data_bits;
  logic                  cfg_parity_en, cfg_two_stop;
  logic                  busy, bit_start, bit_mid, last_bit, frame_done;
  logic [IDX_WIDTH-1:0]  bit_index;

  uart_frame_timer #(
    .DIV_WIDTH     (DIV_WIDTH),
    .MAX_DATA_BITS (MAX_DATA_BITS),
    .FRAC_WIDTH    (FRAC_WIDTH),
    .IDX_WIDTH     (IDX_WIDTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_divisor   (cfg_divisor),
    .cfg_frac      (cfg_frac),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_two_stop  (cfg_two_stop),
    .busy          (busy),
    .bit_start     (bit_start),
    .bit_mid       (bit_mid),
    .bit_index     (bit_index),
    .last_bit      (last_bit),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Reference model: absolute begin cycle of every slot of the accepted frame.
  bit m_active = 1'b0;
  int m_T, m_N, m_p;
  int m_sb[17];

  logic obs_busy, obs_bs, obs_bm, obs_last, obs_done;
  logic [IDX_WIDTH-1:0] obs_idx;

  typedef struct {
    int div; int db; int par; int two; int frac;
    int exp_n; int exp_len; int exp_len_frac;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_accept();
    int d, len, f;
    d = int'(cfg_data_bits);
    if (d < 5) d = 5;
    if (d > MAX_DATA_BITS) d = MAX_DATA_BITS;
    m_p = (int'(cfg_divisor) < 2) ? 2 : int'(cfg_divisor);
    m_N = 1 + d + int'(cfg_parity_en) + (cfg_two_stop ? 2 : 1);
    m_T = cyc + 1;
    f = int'(cfg_frac);
    m_sb[0] = m_T;
    for (int k = 0; k < m_N; k++) begin
      len = m_p;
`ifdef UART_FRAC_BAUD_EN
      len += ((k + 1) * f) / (1 << FRAC_WIDTH) - (k * f) / (1 << FRAC_WIDTH);
`endif
      m_sb[k+1] = m_sb[k] + len;
    end
    if (f < 0) m_sb[0] = m_T;
    m_active = 1'b1;
  endfunction

  task automatic model_check();
    int e_busy, e_bs, e_bm, e_idx, e_last, e_done;
    e_busy = 0; e_bs = 0; e_bm = 0; e_idx = 0; e_last = 0; e_done = 0;
    if (m_active && cyc >= m_T && cyc < m_sb[m_N]) begin
      e_busy = 1;
      for (int k = 0; k < m_N; k++) begin
        if (cyc >= m_sb[k] && cyc < m_sb[k+1]) begin
          e_idx  = k;
          e_bs   = (cyc == m_sb[k]) ? 1 : 0;
          e_bm   = (cyc == m_sb[k] + m_p / 2) ? 1 : 0;
          e_last = (k == m_N - 1) ? 1 : 0;
        end
      end
    end
    if (m_active && cyc == m_sb[m_N]) e_done = 1;
    chk("busy", 32'(obs_busy), 32'(e_busy));
    chk("bit_start", 32'(obs_bs), 32'(e_bs));
    chk("bit_mid", 32'(obs_bm), 32'(e_bm));
    chk("bit_index", 32'(obs_idx), 32'(e_idx));
    chk("last_bit", 32'(obs_last), 32'(e_last));
    chk("frame_done", 32'(obs_done), 32'(e_done));
  endtask

  function automatic void model_update(input bit st, input bit ab, input bit rs);
    bit busy_now;
    busy_now = m_active && cyc >= m_T && cyc < m_sb[m_N];
    if (rs) m_active = 1'b0;
    else if (ab) begin
      if (busy_now) m_active = 1'b0;
    end else if (st && !busy_now) model_accept();
  endfunction

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic cycle(input bit st, input bit ab, input bit rs);
    start = st; abort = ab; reset = rs;
    @(negedge clk);
    obs_busy = busy; obs_bs = bit_start; obs_bm = bit_mid;
    obs_idx = bit_index; obs_last = last_bit; obs_done = frame_done;
    if (chk_en) model_check();
    @(posedge clk);
    model_update(st, ab, rs);
    if (rs) chk_en = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic set_cfg(input int div, input int db, input int par, input int two, input int frac);
    cfg_divisor   = DIV_WIDTH'(div);
    cfg_data_bits = 4'(db);
    cfg_parity_en = par[0];
    cfg_two_stop  = two[0];
    cfg_frac      = FRAC_WIDTH'(frac);
  endtask

  // Start a frame, scramble cfg, then measure length and slot count.
  task automatic run_frame(input string nm, input int exp_n, input int exp_len);
    int n, starts;
    bit got;
    cycle(1'b1, 1'b0, 1'b0);
    set_cfg($urandom_range(0, 9), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 15));
    n = 0; starts = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (obs_done) begin
        got = 1'b1;
        break;
      end
      starts += int'(obs_bs);
      n++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no frame_done, expected one within 400 cycles", nm);
    end else begin
      chk({nm, "_len"}, 32'(n), 32'(exp_len));
      chk({nm, "_slots"}, 32'(starts), 32'(exp_n));
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected it before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    start = 1'b0; abort = 1'b0; reset = 1'b1;
    set_cfg(5, 8, 0, 0, 0);
    @(posedge clk); #1;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_index", 32'(obs_idx), 32'd0);
    chk("rst_done", 32'(obs_done), 32'd0);

    // Frame-format table.
    vecs[0] = '{5, 8, 0, 0, 0, 10, 50, 50};
    vecs[1] = '{1, 5, 1, 1, 0, 9, 18, 18};
    vecs[2] = '{3, 4, 0, 0, 0, 7, 21, 21};
    vecs[3] = '{2, 15, 1, 1, 0, 13, 26, 26};
    vecs[4] = '{0, 9, 0, 1, 0, 12, 24, 24};
    vecs[5] = '{4, 8, 0, 0, 8, 10, 40, 45};
    vecs[6] = '{7, 6, 1, 0, 3, 9, 63, 64};
    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].div, vecs[i].db, vecs[i].par, vecs[i].two, vecs[i].frac);
`ifdef UART_FRAC_BAUD_EN
      run_frame($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_len_frac);
`else
      run_frame($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_len);
`endif
    end

    // Back-to-back start in the frame_done cycle, then start while busy ignored.
    set_cfg(5, 8, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (50) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("b2b_done", 32'(obs_done), 32'd1);
    chk("b2b_busy", 32'(obs_busy), 32'd0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("busy_start_busy", 32'(obs_busy), 32'd1);
    repeat (29) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("b2b_done2", 32'(obs_done), 32'd1);
    cnt = 0;
    repeat (60) begin
      cycle(1'b0, 1'b0, 1'b0);
      cnt += int'(obs_done) + int'(obs_bs) + int'(obs_busy);
    end
    chk("no_queued_frame", 32'(cnt), 32'd0);

    // Abort at T+12.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("abort_busy", 32'(obs_busy), 32'd0);
    cnt = int'(obs_bs) + int'(obs_bm) + int'(obs_done);
    repeat (60) begin
      cycle(1'b0, 1'b0, 1'b0);
      cnt += int'(obs_bs) + int'(obs_bm) + int'(obs_done);
    end
    chk("abort_quiet", 32'(cnt), 32'd0);

    // Abort together with start in IDLE: abort wins.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("abort_start_idle", 32'(obs_busy), 32'd0);

    // Reset at T+7, then a clean frame.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("midrst_outputs",
        32'({obs_busy, obs_bs, obs_bm, obs_idx, obs_last, obs_done}), 32'd0);
    set_cfg(5, 8, 0, 0, 0);
    run_frame("after_rst", 10, 50);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_cfg($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 15));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
